// File: rtl/mprc_release_arbiter.sv
// mprc_release_arbiter
//
// Merges 4-beat writeback data releases with single-beat probe-ack releases
// into one outer release stream, buffered by a DEPTH-entry FIFO. A writeback
// burst is kept atomic: once beat 0 is accepted, probe acks are blocked until
// beat BEATS-1 has been accepted.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// clk edge where valid and ready are both high. Valid must not wait on ready.
// Input readies depend only on FIFO fullness and FSM state, never on
// io_release_ready.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   wb_*                       writeback release input (valid/ready + fields)
//   prb_*                      probe-ack release input (valid/ready + fields)
//   io_release_*               outer release output (valid/ready + fields)
//   err_beat                   sticky beat-order / block-consistency error
//   dbg_state, dbg_count       FSM state (0=IDLE, 1=WB_BURST) and FIFO count
//
// Optional build macro: RELEASE_BEAT_CHECK_EN enables the err_beat checker.
// Without it err_beat is tied low and no checker logic exists.

module mprc_release_arbiter #(
    parameter int DEPTH   = 4,
    parameter int BEATS   = 4,
    parameter int DATA_W  = 128,
    parameter int BLOCK_W = 26
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [1:0]                 wb_addr_beat,
    input  logic [BLOCK_W-1:0]         wb_addr_block,
    input  logic [1:0]                 wb_client_xact_id,
    input  logic                       wb_voluntary,
    input  logic [2:0]                 wb_r_type,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       prb_valid,
    output logic                       prb_ready,
    input  logic [BLOCK_W-1:0]         prb_addr_block,
    input  logic [1:0]                 prb_client_xact_id,
    input  logic [2:0]                 prb_r_type,
    output logic                       io_release_valid,
    input  logic                       io_release_ready,
    output logic [1:0]                 io_release_bits_addr_beat,
    output logic [BLOCK_W-1:0]         io_release_bits_addr_block,
    output logic [1:0]                 io_release_bits_client_xact_id,
    output logic                       io_release_bits_voluntary,
    output logic [2:0]                 io_release_bits_r_type,
    output logic [DATA_W-1:0]          io_release_bits_data,
    output logic                       err_beat,
    output logic                       dbg_state,
    output logic [$clog2(DEPTH+1)-1:0] dbg_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE     = 1'b0,
        WB_BURST = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         beat_cnt_q, beat_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [1:0]         mem_beat_q  [DEPTH];
    logic [BLOCK_W-1:0] mem_block_q [DEPTH];
    logic [1:0]         mem_xact_q  [DEPTH];
    logic               mem_vol_q   [DEPTH];
    logic [2:0]         mem_rtype_q [DEPTH];
    logic [DATA_W-1:0]  mem_data_q  [DEPTH];

    logic               full, empty, enq, deq, wb_acc;
    logic [1:0]         enq_beat;
    logic [BLOCK_W-1:0] enq_block;
    logic [1:0]         enq_xact;
    logic               enq_vol;
    logic [2:0]         enq_rtype;
    logic [DATA_W-1:0]  enq_data;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign deq   = !empty && io_release_ready;
    assign wb_acc = wb_valid && wb_ready;

    // FSM next state, input readies and enqueue selection.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        wb_ready   = !full;
        prb_ready  = 1'b0;
        enq        = 1'b0;
        // Writeback beat order is regenerated from beat_cnt, not taken
        // from wb_addr_beat, so the outer stream always shows 0,1,2,3.
        enq_beat   = beat_cnt_q;
        enq_block  = wb_addr_block;
        enq_xact   = wb_client_xact_id;
        enq_vol    = wb_voluntary;
        enq_rtype  = wb_r_type;
        enq_data   = wb_data;
        unique case (state_q)
            IDLE: begin
                prb_ready = !full && !wb_valid;
                if (wb_acc) begin
                    enq        = 1'b1;
                    beat_cnt_d = 2'd1;
                    state_d    = WB_BURST;
                end else if (prb_valid && prb_ready) begin
                    enq       = 1'b1;
                    enq_beat  = 2'd0;
                    enq_block = prb_addr_block;
                    enq_xact  = prb_client_xact_id;
                    enq_vol   = 1'b0;
                    enq_rtype = prb_r_type;
                    enq_data  = '0;
                end
            end
            WB_BURST: begin
                if (wb_acc) begin
                    enq        = 1'b1;
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    if (beat_cnt_q == 2'(BEATS - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= 2'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            count_q    <= count_d;
            if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_beat_q[wr_ptr_q]  <= enq_beat;
            mem_block_q[wr_ptr_q] <= enq_block;
            mem_xact_q[wr_ptr_q]  <= enq_xact;
            mem_vol_q[wr_ptr_q]   <= enq_vol;
            mem_rtype_q[wr_ptr_q] <= enq_rtype;
            mem_data_q[wr_ptr_q]  <= enq_data;
        end
    end

    assign io_release_valid               = !empty;
    assign io_release_bits_addr_beat      = mem_beat_q[rd_ptr_q];
    assign io_release_bits_addr_block     = mem_block_q[rd_ptr_q];
    assign io_release_bits_client_xact_id = mem_xact_q[rd_ptr_q];
    assign io_release_bits_voluntary      = mem_vol_q[rd_ptr_q];
    assign io_release_bits_r_type         = mem_rtype_q[rd_ptr_q];
    assign io_release_bits_data           = mem_data_q[rd_ptr_q];

    assign dbg_state = state_q;
    assign dbg_count = count_q;

`ifdef RELEASE_BEAT_CHECK_EN
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic               err_q, err_d;

    // Beat 0 latches the burst's block; later beats must match it.
    always_comb begin
        blk_d = blk_q;
        err_d = err_q;
        if (wb_acc) begin
            if (wb_addr_beat != beat_cnt_q) err_d = 1'b1;
            if (state_q == IDLE) begin
                blk_d = wb_addr_block;
            end else if (wb_addr_block != blk_q) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_q <= '0;
            err_q <= 1'b0;
        end else begin
            blk_q <= blk_d;
            err_q <= err_d;
        end
    end

    assign err_beat = err_q;
`else
    logic unused_beat;
    assign unused_beat = ^wb_addr_beat;
    assign err_beat    = 1'b0;
`endif

endmodule

// File: tb/tb_mprc_release_arbiter.sv
module tb_mprc_release_arbiter;

  localparam int DATA_W  = 128;
  localparam int BLOCK_W = 26;

  logic               clk;
  logic               reset;
  logic               wb_valid, wb_ready;
  logic [1:0]         wb_addr_beat;
  logic [BLOCK_W-1:0] wb_addr_block;
  logic [1:0]         wb_client_xact_id;
  logic               wb_voluntary;
  logic [2:0]         wb_r_type;
  logic [DATA_W-1:0]  wb_data;
  logic               prb_valid, prb_ready;
  logic [BLOCK_W-1:0] prb_addr_block;
  logic [1:0]         prb_client_xact_id;
  logic [2:0]         prb_r_type;
  logic               io_release_valid, io_release_ready;
  logic [1:0]         out_beat;
  logic [BLOCK_W-1:0] out_block;
  logic [1:0]         out_xact;
  logic               out_vol;
  logic [2:0]         out_rtype;
  logic [DATA_W-1:0]  out_data;
  logic               err_beat;
  logic               dbg_state;
  logic [2:0]         dbg_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_err;

  mprc_release_arbiter dut (
    .clk                            (clk),
    .reset                          (reset),
    .wb_valid                       (wb_valid),
    .wb_ready                       (wb_ready),
    .wb_addr_beat                   (wb_addr_beat),
    .wb_addr_block                  (wb_addr_block),
    .wb_client_xact_id              (wb_client_xact_id),
    .wb_voluntary                   (wb_voluntary),
    .wb_r_type                      (wb_r_type),
    .wb_data                        (wb_data),
    .prb_valid                      (prb_valid),
    .prb_ready                      (prb_ready),
    .prb_addr_block                 (prb_addr_block),
    .prb_client_xact_id             (prb_client_xact_id),
    .prb_r_type                     (prb_r_type),
    .io_release_valid               (io_release_valid),
    .io_release_ready               (io_release_ready),
    .io_release_bits_addr_beat      (out_beat),
    .io_release_bits_addr_block     (out_block),
    .io_release_bits_client_xact_id (out_xact),
    .io_release_bits_voluntary      (out_vol),
    .io_release_bits_r_type         (out_rtype),
    .io_release_bits_data           (out_data),
    .err_beat                       (err_beat),
    .dbg_state                      (dbg_state),
    .dbg_count                      (dbg_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_addr_beat = '0; wb_addr_block = '0; wb_client_xact_id = '0;
    wb_voluntary = 1'b0; wb_r_type = '0; wb_data = '0;
    prb_valid = 1'b0; prb_addr_block = '0; prb_client_xact_id = '0; prb_r_type = '0;
  endtask

  task automatic drive_wb(input logic [1:0] beat, input logic [BLOCK_W-1:0] blk,
                          input logic [1:0] xact, input logic vol, input logic [2:0] rt,
                          input logic [DATA_W-1:0] d);
    wb_valid = 1'b1; wb_addr_beat = beat; wb_addr_block = blk;
    wb_client_xact_id = xact; wb_voluntary = vol; wb_r_type = rt; wb_data = d;
  endtask

  task automatic drive_prb(input logic [BLOCK_W-1:0] blk, input logic [1:0] xact,
                           input logic [2:0] rt);
    prb_valid = 1'b1; prb_addr_block = blk; prb_client_xact_id = xact; prb_r_type = rt;
  endtask

  task automatic check_out(input string tag, input logic [1:0] beat, input logic [BLOCK_W-1:0] blk,
                           input logic [1:0] xact, input logic vol, input logic [2:0] rt,
                           input logic [DATA_W-1:0] d);
    check_eq({tag, ".valid"}, io_release_valid, 1'b1);
    check_eq({tag, ".beat"},  out_beat,  beat);
    check_eq({tag, ".block"}, out_block, blk);
    check_eq({tag, ".xact"},  out_xact,  xact);
    check_eq({tag, ".vol"},   out_vol,   vol);
    check_eq({tag, ".rtype"}, out_rtype, rt);
    check_eq({tag, ".data"},  out_data,  d);
  endtask

  initial begin
    reset = 1'b0;
    io_release_ready = 1'b1;
    idle_inputs();
    #12;
    // reset state
    check_eq("rst.valid", io_release_valid, 1'b0);
    check_eq("rst.err", err_beat, 1'b0);
    check_eq("rst.wb_ready", wb_ready, 1'b1);
    check_eq("rst.prb_ready", prb_ready, 1'b1);
    check_eq("rst.count", dbg_count, 3'd0);
    check_eq("rst.state", dbg_state, 1'b0);
    reset = 1'b1;
    tick();

    // single writeback, sink always ready
    for (int i = 0; i < 4; i++) begin
      drive_wb(2'(i), 26'h123, 2'd1, 1'b1, 3'd2, 128'hD000 + 128'(i));
      #1;
      check_eq($sformatf("wb1.wb_ready%0d", i), wb_ready, 1'b1);
      check_eq($sformatf("wb1.prb_ready%0d", i), prb_ready, 1'b0);
      tick();
      check_out($sformatf("wb1.out%0d", i), 2'(i), 26'h123, 2'd1, 1'b1, 3'd2, 128'hD000 + 128'(i));
      check_eq($sformatf("wb1.state%0d", i), dbg_state, (i == 3) ? 1'b0 : 1'b1);
    end
    idle_inputs();
    tick();
    check_eq("wb1.drained", io_release_valid, 1'b0);

    // lone probe ack
    drive_prb(26'h55, 2'd2, 3'd3);
    #1;
    check_eq("prb.ready", prb_ready, 1'b1);
    tick();
    idle_inputs();
    check_out("prb.out", 2'd0, 26'h55, 2'd2, 1'b0, 3'd3, '0);
    tick();
    check_eq("prb.drained", io_release_valid, 1'b0);

    // collision in IDLE with a gap inside the burst
    drive_prb(26'h66, 2'd1, 3'd4);
    drive_wb(2'd0, 26'h2AA, 2'd3, 1'b0, 3'd5, 128'hE000);
    #1;
    check_eq("col.prb_ready0", prb_ready, 1'b0);
    tick();
    check_out("col.out0", 2'd0, 26'h2AA, 2'd3, 1'b0, 3'd5, 128'hE000);
    drive_wb(2'd1, 26'h2AA, 2'd3, 1'b0, 3'd5, 128'hE001);
    #1;
    check_eq("col.prb_ready1", prb_ready, 1'b0);
    tick();
    check_out("col.out1", 2'd1, 26'h2AA, 2'd3, 1'b0, 3'd5, 128'hE001);
    wb_valid = 1'b0;
    #1;
    check_eq("col.prb_ready_gap", prb_ready, 1'b0);
    tick();
    check_eq("col.gap_valid", io_release_valid, 1'b0);
    check_eq("col.gap_state", dbg_state, 1'b1);
    drive_wb(2'd2, 26'h2AA, 2'd3, 1'b0, 3'd5, 128'hE002);
    #1;
    check_eq("col.prb_ready2", prb_ready, 1'b0);
    tick();
    check_out("col.out2", 2'd2, 26'h2AA, 2'd3, 1'b0, 3'd5, 128'hE002);
    drive_wb(2'd3, 26'h2AA, 2'd3, 1'b0, 3'd5, 128'hE003);
    #1;
    check_eq("col.prb_ready3", prb_ready, 1'b0);
    tick();
    check_out("col.out3", 2'd3, 26'h2AA, 2'd3, 1'b0, 3'd5, 128'hE003);
    wb_valid = 1'b0;
    #1;
    check_eq("col.prb_ready_after", prb_ready, 1'b1);
    tick();
    prb_valid = 1'b0;
    check_out("col.prb_out", 2'd0, 26'h66, 2'd1, 1'b0, 3'd4, '0);
    tick();
    check_eq("col.drained", io_release_valid, 1'b0);

    // backpressure: fill the FIFO, nothing accepted when full
    io_release_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_wb(2'(i), 26'h200, 2'd0, 1'b1, 3'd1, 128'h2000 + 128'(i));
      tick();
    end
    check_eq("bp.count_full", dbg_count, 3'd4);
    drive_wb(2'd0, 26'h300, 2'd0, 1'b1, 3'd1, 128'h3000);
    drive_prb(26'h77, 2'd0, 3'd0);
    #1;
    check_eq("bp.wb_ready_full", wb_ready, 1'b0);
    check_eq("bp.prb_ready_full", prb_ready, 1'b0);
    tick();
    check_eq("bp.count_held", dbg_count, 3'd4);
    check_eq("bp.state_held", dbg_state, 1'b0);
    idle_inputs();
    io_release_ready = 1'b1;
    #1;
    check_eq("bp.wb_ready_sink_ready", wb_ready, 1'b0);
    check_out("bp.head0", 2'd0, 26'h200, 2'd0, 1'b1, 3'd1, 128'h2000);
    tick();
    check_eq("bp.count3", dbg_count, 3'd3);
    check_eq("bp.wb_ready_back", wb_ready, 1'b1);
    for (int i = 1; i < 4; i++) begin
      check_out($sformatf("bp.head%0d", i), 2'(i), 26'h200, 2'd0, 1'b1, 3'd1, 128'h2000 + 128'(i));
      tick();
    end
    check_eq("bp.drained", io_release_valid, 1'b0);
    check_eq("bp.count0", dbg_count, 3'd0);
    check_eq("bp.err", err_beat, 1'b0);

    // reset mid-burst
    io_release_ready = 1'b0;
    drive_wb(2'd0, 26'h3F0, 2'd2, 1'b1, 3'd6, 128'hF000);
    tick();
    drive_wb(2'd1, 26'h3F0, 2'd2, 1'b1, 3'd6, 128'hF001);
    tick();
    check_eq("mid.state_burst", dbg_state, 1'b1);
    idle_inputs();
    reset = 1'b0;
    #1;
    check_eq("mid.valid", io_release_valid, 1'b0);
    check_eq("mid.state", dbg_state, 1'b0);
    check_eq("mid.count", dbg_count, 3'd0);
    #1;
    reset = 1'b1;
    io_release_ready = 1'b1;
    drive_prb(26'h77, 2'd3, 3'd1);
    #1;
    check_eq("mid.prb_ready", prb_ready, 1'b1);
    tick();
    idle_inputs();
    check_out("mid.prb_out", 2'd0, 26'h77, 2'd3, 1'b0, 3'd1, '0);
    tick();

`ifdef RELEASE_BEAT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    // beat-order error: beat 2 tagged as 3
    drive_wb(2'd0, 26'h400, 2'd0, 1'b1, 3'd1, 128'h4000);
    tick();
    drive_wb(2'd1, 26'h400, 2'd0, 1'b1, 3'd1, 128'h4001);
    tick();
    check_eq("err.before", err_beat, 1'b0);
    drive_wb(2'd3, 26'h400, 2'd0, 1'b1, 3'd1, 128'h4002);
    tick();
    check_eq("err.set", err_beat, exp_err);
    check_out("err.beat_regen", 2'd2, 26'h400, 2'd0, 1'b1, 3'd1, 128'h4002);
    drive_wb(2'd3, 26'h400, 2'd0, 1'b1, 3'd1, 128'h4003);
    tick();
    idle_inputs();
    tick();
    tick();
    check_eq("err.sticky", err_beat, exp_err);
    reset = 1'b0;
    #1;
    check_eq("err.cleared", err_beat, 1'b0);
    #1;
    reset = 1'b1;
    tick();

    // block change inside a burst
    drive_wb(2'd0, 26'h500, 2'd0, 1'b1, 3'd1, 128'h5000);
    tick();
    check_eq("blk.beat0", err_beat, 1'b0);
    drive_wb(2'd1, 26'h501, 2'd0, 1'b1, 3'd1, 128'h5001);
    tick();
    idle_inputs();
    check_eq("blk.set", err_beat, exp_err);
    check_out("blk.out1", 2'd1, 26'h501, 2'd0, 1'b1, 3'd1, 128'h5001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
